// File: rtl/fusion_pkg.sv
// Shared definitions for the fusion column: weight-width modes, lane counts and FSM states.
package fusion_pkg;

  localparam int COL_WIDTH_DEF = 13;

  localparam logic [3:0] MODE_W8 = 4'b1000;
  localparam logic [3:0] MODE_W4 = 4'b0100;

  localparam int LANES_W8  = 1;
  localparam int LANES_W4  = 2;
  localparam int LANES_W2  = 4;
  localparam int MAX_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;
  typedef enum logic [1:0] {LANES_1, LANES_2, LANES_4} lanes_e;

  // 4'b00xx selects the narrowest weights, i.e. four lanes.
  function automatic logic mode_legal(input logic [3:0] ww);
    return (ww == MODE_W8) || (ww == MODE_W4) || (ww[3:2] == 2'b00);
  endfunction

  function automatic lanes_e mode_lanes(input logic [3:0] ww);
    if (ww == MODE_W8) return LANES_1;
    if (ww == MODE_W4) return LANES_2;
    return LANES_4;
  endfunction

endpackage

// File: rtl/fusion_col_accum_lane.sv
// One wide accumulator lane: wrap-around add with clear, enable and sticky overflow flag.
module accum_lane #(
  parameter int ACC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 sgn,
  input  logic [ACC_WIDTH-1:0] addend,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf
);

  logic [ACC_WIDTH:0] sum_wide;
  logic               ovf_now;

  function automatic logic ovf_detect(input logic [ACC_WIDTH-1:0] a,
                                      input logic [ACC_WIDTH-1:0] b,
                                      input logic [ACC_WIDTH:0]   s,
                                      input logic                 is_signed);
    logic signed [ACC_WIDTH-1:0] sa;
    logic signed [ACC_WIDTH-1:0] sb;
    logic signed [ACC_WIDTH-1:0] ss;
    sa = a;
    sb = b;
    ss = s[ACC_WIDTH-1:0];
    if (is_signed)
      return ((sa < 0) == (sb < 0)) && ((ss < 0) != (sa < 0));
    return s[ACC_WIDTH];
  endfunction

  assign sum_wide = {1'b0, acc} + {1'b0, addend};
  assign ovf_now  = ovf_detect(acc, addend, sum_wide, sgn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= sum_wide[ACC_WIDTH-1:0];
      ovf <= ovf | ovf_now;
    end
  end

endmodule

// File: rtl/fusion_col_accum.sv
// Column output accumulator: splits the psum bus into lanes, accumulates a job of passes,
// and hands the wide per-lane sums to the output buffer over valid/ready.
module fusion_col_accum
  import fusion_pkg::*;
#(
  parameter int COL_WIDTH = COL_WIDTH_DEF,
  parameter int ACC_WIDTH = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       num_passes,
  input  logic [3:0]                 weight_width,
  input  logic                       s_mode,
  input  logic                       psum_valid,
  input  logic [4*COL_WIDTH-1:0]     psum_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*ACC_WIDTH-1:0]     out_data,
  output logic                       out_ovf,
  output logic                       busy,
  output logic                       cfg_err,
  output logic                       psum_drop
);

  localparam int BUS_W = 4*COL_WIDTH;

  state_e               state_q, state_d;
  lanes_e               lanes_q, lanes_d;
  logic                 sign_q, sign_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_valid_d, busy_d, cfg_err_d, psum_drop_d;
  logic                 acc_clr, acc_en;

  logic [ACC_WIDTH-1:0] addend   [MAX_LANES];
  logic [ACC_WIDTH-1:0] lane_acc [MAX_LANES];
  logic [MAX_LANES-1:0] lane_ovf;

  // Field occupies the low 'bits' of a zero-filled bus word.
  function automatic logic [ACC_WIDTH-1:0] extend(input logic [BUS_W-1:0] field,
                                                  input int unsigned      bits,
                                                  input logic             sgn);
    logic signed [BUS_W-1:0] t;
    int unsigned             sh;
    sh = BUS_W - bits;
    if (!sgn) return ACC_WIDTH'(field);
    t = $signed(field << sh) >>> sh;
    return ACC_WIDTH'(t);
  endfunction

  always_comb begin
    for (int k = 0; k < MAX_LANES; k++) addend[k] = '0;
    case (lanes_q)
      LANES_1: addend[0] = extend(psum_in, BUS_W, sign_q);
      LANES_2: begin
        addend[0] = extend(BUS_W'(psum_in[2*COL_WIDTH-1:0]), 2*COL_WIDTH, sign_q);
        addend[1] = extend(BUS_W'(psum_in[4*COL_WIDTH-1:2*COL_WIDTH]), 2*COL_WIDTH, sign_q);
      end
      default: begin
        for (int k = 0; k < MAX_LANES; k++)
          addend[k] = extend(BUS_W'(psum_in[COL_WIDTH*k +: COL_WIDTH]), COL_WIDTH, sign_q);
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lanes_d     = lanes_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid;
    cfg_err_d   = 1'b0;
    psum_drop_d = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    case (state_q)
      IDLE: begin
        psum_drop_d = psum_valid;
        if (start) begin
          if (num_passes == '0 || !mode_legal(weight_width)) begin
            cfg_err_d = 1'b1;
          end else begin
            acc_clr = 1'b1;
            lanes_d = mode_lanes(weight_width);
            sign_d  = s_mode;
            cnt_d   = num_passes;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (psum_valid) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d     = DRAIN;
            out_valid_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        psum_drop_d = psum_valid;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lanes_q   <= LANES_1;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      psum_drop <= 1'b0;
    end else begin
      state_q   <= state_d;
      lanes_q   <= lanes_d;
      sign_q    <= sign_d;
      cnt_q     <= cnt_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      cfg_err   <= cfg_err_d;
      psum_drop <= psum_drop_d;
    end
  end

  // Accumulators only move in ACCUM, so out_data is naturally held through DRAIN.
  for (genvar k = 0; k < MAX_LANES; k++) begin : g_lane
    accum_lane #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (acc_clr),
      .en     (acc_en),
      .sgn    (sign_q),
      .addend (addend[k]),
      .acc    (lane_acc[k]),
      .ovf    (lane_ovf[k])
    );
    assign out_data[ACC_WIDTH*k +: ACC_WIDTH] = lane_acc[k];
  end

  assign out_ovf = |lane_ovf;

endmodule

// File: tb/tb_fusion_col_accum.sv
// Directed bench for fusion_col_accum: 64-bit and 52-bit accumulator instances on shared stimulus.
module tb_fusion_col_accum;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   num_passes = '0;
  logic [3:0]   weight_width = '0;
  logic         s_mode = 1'b0;
  logic         psum_valid = 1'b0;
  logic [51:0]  psum_in = '0;
  logic         out_ready = 1'b0;

  logic         out_valid, out_ovf, busy, cfg_err, psum_drop;
  logic [255:0] out_data;
  logic         out_valid52, out_ovf52, busy52, cfg_err52, psum_drop52;
  logic [207:0] out_data52;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fusion_col_accum #(.COL_WIDTH(13), .ACC_WIDTH(64), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_passes(num_passes),
    .weight_width(weight_width), .s_mode(s_mode), .psum_valid(psum_valid),
    .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .busy(busy), .cfg_err(cfg_err),
    .psum_drop(psum_drop)
  );

  fusion_col_accum #(.COL_WIDTH(13), .ACC_WIDTH(52), .CNT_WIDTH(8)) dut52 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_passes(num_passes),
    .weight_width(weight_width), .s_mode(s_mode), .psum_valid(psum_valid),
    .psum_in(psum_in), .out_valid(out_valid52), .out_ready(out_ready),
    .out_data(out_data52), .out_ovf(out_ovf52), .busy(busy52), .cfg_err(cfg_err52),
    .psum_drop(psum_drop52)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] lane(input int k);
    return out_data[64*k +: 64];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input logic [7:0] np, input logic [3:0] ww, input logic sm);
    start = 1'b1; num_passes = np; weight_width = ww; s_mode = sm;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [51:0] d);
    psum_valid = 1'b1; psum_in = d;
    step();
    psum_valid = 1'b0; psum_in = '0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [255:0] held;

  initial begin
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data", out_data[63:0], 64'd0);
    rst_n = 1'b1;
    step();

    // 1-lane signed: -5 + 2 - 1
    begin_job(8'd3, 4'b1000, 1'b1);
    chk("t1_busy", 64'(busy), 64'd1);
    beat(52'hF_FFFF_FFFF_FFFB);
    beat(52'h0_0000_0000_0002);
    chk("t1_valid_early", 64'(out_valid), 64'd0);
    beat(52'hF_FFFF_FFFF_FFFF);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_lane0", lane(0), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t1_lane1", lane(1), 64'd0);
    chk("t1_lane3", lane(3), 64'd0);
    chk("t1_ovf", 64'(out_ovf), 64'd0);
    handshake();
    chk("t1_valid_drop", 64'(out_valid), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // 4-lane unsigned, lane0 carries past 13 bits
    begin_job(8'd2, 4'b0000, 1'b0);
    beat({13'd4, 13'd3, 13'd2, 13'd1});
    beat({13'd1, 13'd1, 13'd1, 13'd8191});
    chk("t2_lane0", lane(0), 64'd8192);
    chk("t2_lane1", lane(1), 64'd3);
    chk("t2_lane2", lane(2), 64'd4);
    chk("t2_lane3", lane(3), 64'd5);
    handshake();

    // 2-lane signed, then backpressure with stray beats in DRAIN
    begin_job(8'd2, 4'b0100, 1'b1);
    beat({26'h3FF_FFFF, 26'd100});
    psum_valid = 1'b1; psum_in = {26'h3FF_FFFF, 26'd100};
    step();
    chk("t3_lane0", lane(0), 64'd200);
    chk("t3_lane1", lane(1), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t3_lane2", lane(2), 64'd0);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      psum_in = 52'(i + 3);
      step();
      chk("bp_drop", 64'(psum_drop), 64'd1);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_lane0", lane(0), held[63:0]);
      chk("bp_lane1", lane(1), held[127:64]);
    end
    psum_valid = 1'b0; psum_in = '0;
    handshake();
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    chk("bp_busy", 64'(busy), 64'd0);
    chk("bp_drop_end", 64'(psum_drop), 64'd0);

    // stray beat in IDLE
    beat(52'd9);
    chk("idle_drop", 64'(psum_drop), 64'd1);
    step();
    chk("idle_drop_clr", 64'(psum_drop), 64'd0);

    // unsigned overflow on the 52-bit accumulator
    begin_job(8'd2, 4'b1000, 1'b0);
    beat(52'h8_0000_0000_0000);
    beat(52'h8_0000_0000_0000);
    chk("ovf52_lane0", 64'(out_data52[51:0]), 64'd0);
    chk("ovf52_flag", 64'(out_ovf52), 64'd1);
    chk("ovf64_lane0", lane(0), 64'h0010_0000_0000_0000);
    chk("ovf64_flag", 64'(out_ovf), 64'd0);
    handshake();

    // rejected starts
    begin_job(8'd0, 4'b1000, 1'b0);
    chk("cfg_zero_err", 64'(cfg_err), 64'd1);
    chk("cfg_zero_busy", 64'(busy), 64'd0);
    step();
    chk("cfg_pulse_end", 64'(cfg_err), 64'd0);
    begin_job(8'd1, 4'b1100, 1'b0);
    chk("cfg_mode_err", 64'(cfg_err), 64'd1);
    chk("cfg_mode_busy", 64'(busy), 64'd0);
    chk("ovf_sticky", 64'(out_ovf52), 64'd1);

    // legal start clears sticky flag; start while busy ignored
    begin_job(8'd4, 4'b1000, 1'b0);
    chk("ovf_cleared", 64'(out_ovf52), 64'd0);
    begin_job(8'd0, 4'b1000, 1'b0);
    chk("busy_start_noerr", 64'(cfg_err), 64'd0);
    beat(52'd123);
    chk("mid_lane0", lane(0), 64'd123);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_lane0", lane(0), 64'd0);
    #2;
    rst_n = 1'b1;
    step();

    begin_job(8'd1, 4'b1000, 1'b0);
    beat(52'd7);
    chk("fresh_valid", 64'(out_valid), 64'd1);
    chk("fresh_lane0", lane(0), 64'd7);
    handshake();
    chk("fresh_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fusion_col_accum.md
Name: fusion_col_accum

Overview:
- Column output accumulator directly downstream of the last fusion unit in a systolic column; consumes its registered psum_fwd bus.
- Splits the bus into 1, 2 or 4 lanes per weight-width mode, sign- or zero-extends each lane, and accumulates a programmed number of passes (tiles).
- Presents the wide per-lane results to the output buffer over a valid/ready handshake.

Parameters:
- COL_WIDTH, 13, per-lane column width of the incoming psum bus; must match the fusion units.
- ACC_WIDTH, 64, per-lane accumulator width; must be ≥ 4*COL_WIDTH.
- CNT_WIDTH, 8, width of the pass counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- num_passes  in  CNT_WIDTH  beats to accumulate; latched at start.
- weight_width  in  4  mode, latched at start: 4'b1000 = 1 lane, 4'b0100 = 2 lanes, 4'b00xx = 4 lanes.
- s_mode  in  1  1 = lanes signed (s_in|s_weight), 0 = unsigned; latched at start.
- psum_valid  in  1  psum_in beat is valid.
- psum_in  in  4*COL_WIDTH  column psum bus.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  4*ACC_WIDTH  lane k at [ACC_WIDTH*(k+1)-1 : ACC_WIDTH*k].
- out_ovf  out  1  sticky overflow for the current job.
- busy  out  1  state != IDLE.
- cfg_err  out  1  one-cycle pulse on a rejected start.
- psum_drop  out  1  one-cycle pulse when psum_valid arrives outside ACCUM.

Behaviour:
- Reset (async, rst_n low): state = IDLE; accumulators, counter, out_data = 0; out_valid, out_ovf, busy, cfg_err, psum_drop = 0. Takes effect immediately, including mid-job; any partial job is discarded.
- Lane extraction, 1-lane mode: lane0 = psum_in[4C-1:0].
- Lane extraction, 2-lane mode: lane0 = [2C-1:0], lane1 = [4C-1:2C].
- Lane extraction, 4-lane mode: lane k = [C(k+1)-1 : Ck].
- Each lane is sign-extended (s_mode = 1) or zero-extended to ACC_WIDTH. Unused lanes stay 0.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE: on start, cfg_err is pulsed next cycle and the state stays IDLE if num_passes == 0 or weight_width is not a legal mode (e.g. 4'b1100, 4'b0110).
- IDLE, legal start: clear accumulators and out_ovf, latch mode, sign and count; go to ACCUM.
- ACCUM: each psum_valid beat adds the extended lanes to the accumulators (wrap arithmetic) and decrements the count. Cycles without psum_valid hold state.
- ACCUM, last beat (count == 1): accumulators update and the state goes to DRAIN. out_valid rises the cycle after that beat edge, with out_data = final sums.
- DRAIN: out_data and out_ovf are held stable while out_valid = 1 and out_ready = 0. On out_valid & out_ready: out_valid drops next cycle and the state returns to IDLE.
- Throughput: a new start is accepted no earlier than the cycle after the handshake.
- start while busy is ignored silently; no cfg_err.
- psum_valid in IDLE or DRAIN: the beat is dropped, accumulators are unchanged, and psum_drop pulses next cycle.
- Overflow (out_ovf) is sticky until the next accepted start:
  - signed: operands share a sign and the sum's sign differs;
  - unsigned: carry out of bit ACC_WIDTH-1.
- All outputs are registered; no combinational path from psum_in or out_ready to any output.

Decomposition:
- Shared package fusion_pkg holds:
  - mode encodings MODE_W8 = 4'b1000, MODE_W4 = 4'b0100;
  - lane-count localparams;
  - FSM state enum {IDLE, ACCUM, DRAIN};
  - COL_WIDTH default, shared with the fusion units.
- One sub-module, accum_lane: a single ACC_WIDTH adder/register with clear, enable, signed flag and sticky overflow output. It is instantiated 4×; the top holds the FSM, lane extraction and handshake.

Test Plan:
- 1-lane signed, num_passes = 3, beats −5, +2, −1 (52-bit two's complement) -> out_valid 1 cycle after beat 3; lane0 = 64'hFFFF_FFFF_FFFF_FFFC; lanes 1–3 = 0; out_ovf = 0.
- 4-lane unsigned, num_passes = 2, beats lanes {1,2,3,4} then {8191,1,1,1} -> lanes = {8192,3,4,5}, showing no 13-bit truncation.
- 2-lane signed, num_passes = 2, lane1 = 26'h3FFFFFF and lane0 = 26'd100 each beat -> lane1 = −2 (all ones except LSB), lane0 = 200.
- Backpressure: hold out_ready = 0 for 5 cycles in DRAIN while driving psum_valid -> out_data and out_valid stable, psum_drop pulses per beat, result unchanged; out_ready = 1 -> out_valid low next cycle, busy = 0.
- Config errors and overflow:
  - start with num_passes = 0 -> cfg_err pulse, busy stays 0;
  - start with weight_width = 4'b1100 -> cfg_err pulse;
  - ACC_WIDTH = 52, 1-lane unsigned, two beats of 2^51 -> lane0 = 0, out_ovf = 1.
- rst_n low mid-ACCUM after 1 of 4 beats -> busy, out_valid, out_data = 0 immediately. Then a fresh 1-pass job with value 7 -> lane0 = 7, no residue.
